// File: rtl/seq_divider_pkg.sv
// Shared divider definitions: FSM state encodings and the default operand width,
// used by the controller, the step datapath and anything decoding a debug state.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } divState_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor if it fits. Purely combinational.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             dvdMsb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] nextPrem,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // prem < dvs always holds, so the shifted value fits in WIDTH+1 bits
  assign shifted  = {prem, dvdMsb};
  assign trial    = shifted - {1'b0, dvs};
  assign qBit     = (shifted >= {1'b0, dvs});
  assign nextPrem = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider answering the div_start/div_fim handshake:
// truncating quotient to LO, dividend-signed remainder to HI, zero-divisor flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  divState_e        state;
  divState_e        stateNext;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] count;
  logic             signQ;
  logic             signR;
  logic [WIDTH-1:0] nextPrem;
  logic             qBit;
  logic [WIDTH-1:0] absDividend;
  logic [WIDTH-1:0] absDivisor;
  logic             lastStep;

  assign absDividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign absDivisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign lastStep    = (count == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) uStep (
    .prem     (prem),
    .dvdMsb   (dvd[WIDTH-1]),
    .dvs      (dvs),
    .nextPrem (nextPrem),
    .qBit     (qBit)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: if (start) stateNext = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (lastStep) stateNext = S_FIX;
      S_FIX:  stateNext = S_DONE;
      S_DONE: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; done/busy are decoded from the next state
  always_ff @(posedge clock) begin
    if (!reset) begin
      prem      <= '0;
      dvd       <= '0;
      dvs       <= '0;
      count     <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= (stateNext == S_DONE);
      busy <= (stateNext != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
            end else begin
              div_zero <= 1'b0;
              dvd      <= absDividend;
              dvs      <= absDivisor;
              signQ    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              signR    <= dividend[WIDTH-1];
              prem     <= '0;
              count    <= '0;
            end
          end
        end
        S_RUN: begin
          prem  <= nextPrem;
          dvd   <= {dvd[WIDTH-2:0], qBit};
          count <= count + CNT_W'(1);
        end
        S_FIX: begin
          quotient  <= signQ ? -dvd : dvd;
          remainder <= signR ? -prem : prem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signs, zero divisor, overflow, reset abort, held start.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        div_zero;
  logic        busy;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  always #5 clock = ~clock;

  seq_divider dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one division, scramble operands while it runs, check latency and results
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expQ, input logic [31:0] expR,
                        input logic expZero, input bit hold);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    check({tag, ":busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clock); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, expZero ? 32'd0 : 32'd33);
    check({tag, ":quotient"}, quotient, expQ);
    check({tag, ":remainder"}, remainder, expR);
    check({tag, ":div_zero"}, {31'd0, div_zero}, {31'd0, expZero});
    @(posedge clock); #1;
    check({tag, ":done_drop"}, {31'd0, done}, 32'd0);
    check({tag, ":idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int doneSeen;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_flags", {29'd0, done, div_zero, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    runDiv("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    runDiv("zero_div", 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 1'b0);
    runDiv("neg_pos", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runDiv("pos_neg", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    runDiv("neg_neg", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runDiv("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    runDiv("small", 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 1'b0);
    runDiv("max_by_one", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);

    // Abort a division with reset at edge 10
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_flags", {29'd0, done, div_zero, busy}, 32'd0);
    reset = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) doneSeen++;
    end
    check("abort_no_done", doneSeen, 32'd0);
    runDiv("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    // Start held high: each return to IDLE accepts the operands present then
    runDiv("hold_1", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b1);
    runDiv("hold_2", -32'sd17, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 1'b1);
    runDiv("hold_3", 32'd1000, -32'sd33, 32'hFFFF_FFE2, 32'd10, 1'b0, 1'b1);
    start = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) doneSeen++;
    end
    check("hold_release", doneSeen, 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
